// File: rtl/ram_1rw1w_port_ctrl_pkg.sv
// Shared types and elaboration helpers for the 1rw1w RAM request front end.
// Widths remain module parameters; only the arbiter pointer type and the clog2 helper live here.
package ram_1rw1w_port_ctrl_pkg;

    // Round-robin pointer for port 0: names the requester that wins the next contested cycle.
    typedef enum logic {
        RR_READ  = 1'b0,
        RR_WRITE = 1'b1
    } rr_e;

    // clog2 that never returns 0, so a 1-entry structure still gets a 1-bit index.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_rd_resp_buf.sv
// Circular read-response buffer: pushes captured RAM read data, pops toward the consumer.
// Has no overflow protection of its own; the upstream credit count guarantees a free slot on every push.
module ram_rd_resp_buf
    import ram_1rw1w_port_ctrl_pkg::*;
#(
    parameter int width_p = 512,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               push_i,
    input  logic [width_p-1:0] data_i,
    input  logic               pop_i,
    output logic               val_o,
    output logic [width_p-1:0] data_o
);

    localparam int ptr_width_lp = safe_clog2(els_p);
    localparam int cnt_width_lp = safe_clog2(els_p + 1);
    localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);

    logic [ptr_width_lp-1:0] wr_ptr_q, wr_ptr_d;
    logic [ptr_width_lp-1:0] rd_ptr_q, rd_ptr_d;
    logic [cnt_width_lp-1:0] count_q, count_d;
    logic [width_p-1:0]      mem_q [els_p];
    logic                    do_pop;

    assign val_o  = (count_q != '0);
    assign data_o = mem_q[rd_ptr_q];
    assign do_pop = pop_i & val_o;

    // Pointers wrap explicitly at els_p, so a non-power-of-two depth works.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = (wr_ptr_q == last_ptr_lp) ? '0 : wr_ptr_q + ptr_width_lp'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == last_ptr_lp) ? '0 : rd_ptr_q + ptr_width_lp'(1);
        end
        case ({push_i, do_pop})
            2'b10:   count_d = count_q + cnt_width_lp'(1);
            2'b01:   count_d = count_q - cnt_width_lp'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/ram_1rw1w_port_ctrl.sv
// Request front end for the banked 1rw1w byte-mask RAM: arbitrates read / write-0 onto port 0,
// forwards write-1 to port 1, and returns 1-cycle sync read data through a credit-limited buffer.
module ram_1rw1w_port_ctrl
    import ram_1rw1w_port_ctrl_pkg::*;
#(
    parameter int width_p       = 512,
    parameter int els_p         = 256,
    parameter int rd_buf_els_p  = 2,
    parameter int addr_width_lp = safe_clog2(els_p),
    parameter int mask_width_lp = width_p / 8
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,

    input  logic                     rd_req_val_i,
    input  logic [addr_width_lp-1:0] rd_req_addr_i,
    output logic                     rd_req_rdy_o,
    output logic                     rd_resp_val_o,
    output logic [width_p-1:0]       rd_resp_data_o,
    input  logic                     rd_resp_rdy_i,

    input  logic                     wr0_req_val_i,
    input  logic [addr_width_lp-1:0] wr0_req_addr_i,
    input  logic [width_p-1:0]       wr0_req_data_i,
    input  logic [mask_width_lp-1:0] wr0_req_mask_i,
    output logic                     wr0_req_rdy_o,

    input  logic                     wr1_req_val_i,
    input  logic [addr_width_lp-1:0] wr1_req_addr_i,
    input  logic [width_p-1:0]       wr1_req_data_i,
    input  logic [mask_width_lp-1:0] wr1_req_mask_i,
    output logic                     wr1_req_rdy_o,

    output logic                     v0_o,
    output logic                     w0_o,
    output logic [addr_width_lp-1:0] addr0_o,
    output logic [width_p-1:0]       w0_data_o,
    output logic [mask_width_lp-1:0] w0_mask_o,
    input  logic [width_p-1:0]       r0_data_i,

    output logic                     v1_o,
    output logic                     w1_o,
    output logic [addr_width_lp-1:0] addr1_o,
    output logic [width_p-1:0]       w1_data_o,
    output logic [mask_width_lp-1:0] w1_mask_o
);

    localparam int cred_width_lp = safe_clog2(rd_buf_els_p + 1);
    localparam logic [cred_width_lp-1:0] cred_max_lp = cred_width_lp'(rd_buf_els_p);

    logic [cred_width_lp-1:0] credits_q, credits_d;
    logic                     inflight_q, inflight_d;
    rr_e                      rr_q, rr_d;

    logic                     rd_pop;
    logic                     rd_room;
    logic                     rd_elig;
    logic                     wr0_elig;
    logic                     gnt_rd;
    logic                     gnt_wr0;
    logic                     buf_val;
    logic [width_p-1:0]       buf_data;

    assign rd_resp_val_o  = buf_val & reset_n_i;
    assign rd_resp_data_o = buf_data;
    assign rd_pop         = rd_resp_val_o & rd_resp_rdy_i;

    // A slot freed by this cycle's pop can be reissued in the same cycle; without this
    // a depth-2 buffer would bubble every third cycle under a continuous read stream.
    assign rd_room = (credits_q < cred_max_lp) | rd_pop;

    always_comb begin
        rd_elig  = reset_n_i & rd_req_val_i & rd_room;
        wr0_elig = reset_n_i & wr0_req_val_i;
        gnt_rd   = 1'b0;
        gnt_wr0  = 1'b0;
        rr_d     = rr_q;
        if (rd_elig && wr0_elig) begin
            if (rr_q == RR_READ) begin
                gnt_rd = 1'b1;
                rr_d   = RR_WRITE;
            end else begin
                gnt_wr0 = 1'b1;
                rr_d    = RR_READ;
            end
        end else begin
            gnt_rd  = rd_elig;
            gnt_wr0 = wr0_elig;
        end
    end

    assign rd_req_rdy_o  = gnt_rd;
    assign wr0_req_rdy_o = gnt_wr0;

    // Port 0 is driven straight from this cycle's grant; no request-path registers.
    always_comb begin
        v0_o      = gnt_rd | gnt_wr0;
        w0_o      = gnt_wr0;
        addr0_o   = gnt_wr0 ? wr0_req_addr_i : rd_req_addr_i;
        w0_data_o = wr0_req_data_i;
        w0_mask_o = gnt_wr0 ? wr0_req_mask_i : '0;
    end

    assign wr1_req_rdy_o = reset_n_i;
    assign v1_o          = reset_n_i & wr1_req_val_i;
    assign w1_o          = reset_n_i & wr1_req_val_i;
    assign addr1_o       = wr1_req_addr_i;
    assign w1_data_o     = wr1_req_data_i;
    assign w1_mask_o     = wr1_req_mask_i;

    // Credits cover reads in flight plus entries already buffered.
    always_comb begin
        credits_d  = credits_q;
        inflight_d = gnt_rd;
        if (gnt_rd && !rd_pop) begin
            credits_d = credits_q + cred_width_lp'(1);
        end else if (!gnt_rd && rd_pop) begin
            credits_d = credits_q - cred_width_lp'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            credits_q  <= '0;
            inflight_q <= 1'b0;
            rr_q       <= RR_READ;
        end else begin
            credits_q  <= credits_d;
            inflight_q <= inflight_d;
            rr_q       <= rr_d;
        end
    end

    // The RAM presents read data the cycle after issue, which is when inflight_q is high.
    ram_rd_resp_buf #(
        .width_p (width_p),
        .els_p   (rd_buf_els_p)
    ) u_rd_resp_buf (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (inflight_q),
        .data_i    (r0_data_i),
        .pop_i     (rd_resp_rdy_i),
        .val_o     (buf_val),
        .data_o    (buf_data)
    );

endmodule

// File: tb/tb_ram_1rw1w_port_ctrl.sv
// Directed bench for ram_1rw1w_port_ctrl with a behavioural 1-cycle sync RAM and a response scoreboard.
module tb_ram_1rw1w_port_ctrl;

    localparam int W  = 32;
    localparam int E  = 16;
    localparam int D  = 2;
    localparam int AW = 4;
    localparam int MW = W / 8;

    logic          clk;
    logic          rst_n;
    logic          rd_req_val_i;
    logic [AW-1:0] rd_req_addr_i;
    logic          rd_req_rdy_o;
    logic          rd_resp_val_o;
    logic [W-1:0]  rd_resp_data_o;
    logic          rd_resp_rdy_i;
    logic          wr0_req_val_i;
    logic [AW-1:0] wr0_req_addr_i;
    logic [W-1:0]  wr0_req_data_i;
    logic [MW-1:0] wr0_req_mask_i;
    logic          wr0_req_rdy_o;
    logic          wr1_req_val_i;
    logic [AW-1:0] wr1_req_addr_i;
    logic [W-1:0]  wr1_req_data_i;
    logic [MW-1:0] wr1_req_mask_i;
    logic          wr1_req_rdy_o;
    logic          v0_o, w0_o, v1_o, w1_o;
    logic [AW-1:0] addr0_o, addr1_o;
    logic [W-1:0]  w0_data_o, w1_data_o;
    logic [MW-1:0] w0_mask_o, w1_mask_o;
    logic [W-1:0]  r0_data_q;

    logic          ram_init;
    logic [W-1:0]  ram_mem [E];
    logic [W-1:0]  ref_mem [E];
    logic [W-1:0]  exp_q [$];
    int            total;
    int            bad;

    ram_1rw1w_port_ctrl #(
        .width_p      (W),
        .els_p        (E),
        .rd_buf_els_p (D)
    ) dut (
        .clk_i          (clk),
        .reset_n_i      (rst_n),
        .rd_req_val_i   (rd_req_val_i),
        .rd_req_addr_i  (rd_req_addr_i),
        .rd_req_rdy_o   (rd_req_rdy_o),
        .rd_resp_val_o  (rd_resp_val_o),
        .rd_resp_data_o (rd_resp_data_o),
        .rd_resp_rdy_i  (rd_resp_rdy_i),
        .wr0_req_val_i  (wr0_req_val_i),
        .wr0_req_addr_i (wr0_req_addr_i),
        .wr0_req_data_i (wr0_req_data_i),
        .wr0_req_mask_i (wr0_req_mask_i),
        .wr0_req_rdy_o  (wr0_req_rdy_o),
        .wr1_req_val_i  (wr1_req_val_i),
        .wr1_req_addr_i (wr1_req_addr_i),
        .wr1_req_data_i (wr1_req_data_i),
        .wr1_req_mask_i (wr1_req_mask_i),
        .wr1_req_rdy_o  (wr1_req_rdy_o),
        .v0_o           (v0_o),
        .w0_o           (w0_o),
        .addr0_o        (addr0_o),
        .w0_data_o      (w0_data_o),
        .w0_mask_o      (w0_mask_o),
        .r0_data_i      (r0_data_q),
        .v1_o           (v1_o),
        .w1_o           (w1_o),
        .addr1_o        (addr1_o),
        .w1_data_o      (w1_data_o),
        .w1_mask_o      (w1_mask_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // behavioural RAM: masked writes on both ports, 1-cycle sync read on port 0
    always @(posedge clk) begin
        if (ram_init) begin
            for (int k = 0; k < E; k++) ram_mem[k] <= W'(k * 3);
        end else begin
            if (v1_o && w1_o) begin
                for (int b = 0; b < MW; b++)
                    if (w1_mask_o[b]) ram_mem[addr1_o][b*8 +: 8] <= w1_data_o[b*8 +: 8];
            end
            if (v0_o) begin
                if (w0_o) begin
                    for (int b = 0; b < MW; b++)
                        if (w0_mask_o[b]) ram_mem[addr0_o][b*8 +: 8] <= w0_data_o[b*8 +: 8];
                end else begin
                    r0_data_q <= ram_mem[addr0_o];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // scoreboard: push expected data on read accept, pop and compare on response handshake
    always @(negedge clk) begin
        if (ram_init) begin
            for (int k = 0; k < E; k++) ref_mem[k] = W'(k * 3);
        end else if (rst_n) begin
            if (rd_resp_val_o && rd_resp_rdy_i) begin
                chk("resp_expected", W'(exp_q.size() != 0), W'(1));
                if (exp_q.size() != 0) chk("resp_data", rd_resp_data_o, exp_q.pop_front());
            end
            if (rd_req_val_i && rd_req_rdy_o) exp_q.push_back(ref_mem[rd_req_addr_i]);
            if (wr0_req_val_i && wr0_req_rdy_o) begin
                for (int b = 0; b < MW; b++)
                    if (wr0_req_mask_i[b]) ref_mem[wr0_req_addr_i][b*8 +: 8] = wr0_req_data_i[b*8 +: 8];
            end
            if (wr1_req_val_i && wr1_req_rdy_o) begin
                for (int b = 0; b < MW; b++)
                    if (wr1_req_mask_i[b]) ref_mem[wr1_req_addr_i][b*8 +: 8] = wr1_req_data_i[b*8 +: 8];
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        rd_resp_rdy_i = 1'b1;
        while (exp_q.size() != 0 && n < budget) begin
            next_cycle();
            n++;
        end
        chk("drain_empty", W'(exp_q.size()), W'(0));
    endtask

    initial begin
        int acc;
        int ra;
        int wa;
        int n;
        logic wr_new;
        logic exp_rd;
        logic [W-1:0] wd;
        logic [MW-1:0] wm;

        total = 0;
        bad = 0;
        rst_n = 1'b0;
        ram_init = 1'b1;
        rd_req_addr_i = '0;
        rd_resp_rdy_i = 1'b1;
        wr0_req_addr_i = '0;
        wr0_req_data_i = '0;
        wr0_req_mask_i = '0;
        wr1_req_addr_i = '0;
        wr1_req_data_i = '0;
        wr1_req_mask_i = '0;
        rd_req_val_i = 1'b1;
        wr0_req_val_i = 1'b1;
        wr1_req_val_i = 1'b1;

        // reset: all handshakes and RAM enables held low
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rd_rdy", W'(rd_req_rdy_o), W'(0));
        chk("reset_wr0_rdy", W'(wr0_req_rdy_o), W'(0));
        chk("reset_wr1_rdy", W'(wr1_req_rdy_o), W'(0));
        chk("reset_v0", W'(v0_o), W'(0));
        chk("reset_v1", W'(v1_o), W'(0));
        chk("reset_resp_val", W'(rd_resp_val_o), W'(0));
        next_cycle();
        rd_req_val_i = 1'b0;
        wr0_req_val_i = 1'b0;
        wr1_req_val_i = 1'b0;
        ram_init = 1'b0;
        rst_n = 1'b1;
        next_cycle();

        // back-to-back reads of addr 0..7, response valid from 2 cycles after first accept
        for (int j = 0; j < 11; j++) begin
            rd_req_val_i = (j < 8);
            rd_req_addr_i = AW'(j);
            @(negedge clk);
            if (j < 8) chk("t1_rd_rdy", W'(rd_req_rdy_o), W'(1));
            chk("t1_resp_val", W'(rd_resp_val_o), W'(j >= 2 && j <= 9));
            next_cycle();
        end
        rd_req_val_i = 1'b0;
        drain(10);

        // consumer stalls: credits fill at 2, then release and complete 4 reads in order
        rd_resp_rdy_i = 1'b0;
        acc = 0;
        for (int j = 0; j < 5; j++) begin
            rd_req_val_i = 1'b1;
            rd_req_addr_i = AW'(8 + acc);
            @(negedge clk);
            chk("t2_rd_rdy", W'(rd_req_rdy_o), W'(j < 2));
            if (j >= 2) chk("t2_resp_held", W'(rd_resp_val_o), W'(1));
            if (rd_req_rdy_o) acc++;
            next_cycle();
        end
        rd_resp_rdy_i = 1'b1;
        n = 0;
        while (acc < 4 && n < 10) begin
            rd_req_val_i = 1'b1;
            rd_req_addr_i = AW'(8 + acc);
            @(negedge clk);
            if (rd_req_rdy_o) acc++;
            next_cycle();
            n++;
        end
        rd_req_val_i = 1'b0;
        chk("t2_accepted", W'(acc), W'(4));
        drain(10);

        // read and write 0 contend: grants alternate starting with read
        ra = 0;
        wa = 12;
        wr_new = 1'b1;
        rd_req_val_i = 1'b1;
        wr0_req_val_i = 1'b1;
        for (int j = 0; j < 6; j++) begin
            rd_req_addr_i = AW'(ra);
            wr0_req_addr_i = AW'(wa);
            if (wr_new) begin
                wr0_req_data_i = W'($urandom);
                wr0_req_mask_i = MW'($urandom_range(1, 15));
            end
            @(negedge clk);
            exp_rd = ((j % 2) == 0);
            chk("t3_rd_gnt", W'(rd_req_rdy_o), W'(exp_rd));
            chk("t3_wr_gnt", W'(wr0_req_rdy_o), W'(!exp_rd));
            chk("t3_w0", W'(w0_o), W'(!exp_rd));
            chk("t3_v0", W'(v0_o), W'(1));
            wr_new = wr0_req_rdy_o;
            if (rd_req_rdy_o) ra++;
            if (wr0_req_rdy_o) wa++;
            next_cycle();
        end
        rd_req_val_i = 1'b0;
        wr0_req_val_i = 1'b0;
        drain(10);

        // write 0 byte 0 of addr 5, read it back the next cycle
        wr0_req_val_i = 1'b1;
        wr0_req_addr_i = AW'(5);
        wr0_req_data_i = W'(32'h0000_00AA);
        wr0_req_mask_i = MW'(1);
        @(negedge clk);
        chk("t4_wr_rdy", W'(wr0_req_rdy_o), W'(1));
        chk("t4_addr0", W'(addr0_o), W'(5));
        chk("t4_mask0", W'(w0_mask_o), W'(1));
        next_cycle();
        wr0_req_val_i = 1'b0;
        rd_req_val_i = 1'b1;
        rd_req_addr_i = AW'(5);
        @(negedge clk);
        chk("t4_rd_rdy", W'(rd_req_rdy_o), W'(1));
        next_cycle();
        rd_req_val_i = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("t4_resp_val", W'(rd_resp_val_o), W'(1));
        chk("t4_resp_data", rd_resp_data_o, W'(32'h0000_00AA));
        next_cycle();
        drain(10);

        // write 1 every cycle alongside a port-0 read stream
        for (int j = 0; j < 6; j++) begin
            wd = W'($urandom);
            wm = MW'($urandom_range(0, 15));
            rd_req_val_i = 1'b1;
            rd_req_addr_i = AW'(j);
            wr1_req_val_i = 1'b1;
            wr1_req_addr_i = AW'(8 + j);
            wr1_req_data_i = wd;
            wr1_req_mask_i = wm;
            @(negedge clk);
            chk("t5_wr1_rdy", W'(wr1_req_rdy_o), W'(1));
            chk("t5_v1", W'(v1_o), W'(1));
            chk("t5_w1", W'(w1_o), W'(1));
            chk("t5_addr1", W'(addr1_o), W'(8 + j));
            chk("t5_data1", w1_data_o, wd);
            chk("t5_mask1", W'(w1_mask_o), W'(wm));
            chk("t5_rd_rdy", W'(rd_req_rdy_o), W'(1));
            next_cycle();
        end
        rd_req_val_i = 1'b0;
        wr1_req_val_i = 1'b0;
        drain(10);

        // reset with one buffered and one in-flight read
        rd_resp_rdy_i = 1'b0;
        rd_req_val_i = 1'b1;
        rd_req_addr_i = AW'(3);
        @(negedge clk);
        chk("t6_rd_a", W'(rd_req_rdy_o), W'(1));
        next_cycle();
        rd_req_addr_i = AW'(4);
        @(negedge clk);
        chk("t6_rd_b", W'(rd_req_rdy_o), W'(1));
        next_cycle();
        rd_req_val_i = 1'b0;
        @(negedge clk);
        chk("t6_buffered", W'(rd_resp_val_o), W'(1));
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_val_drop", W'(rd_resp_val_o), W'(0));
        chk("t6_wr1_rdy_rst", W'(wr1_req_rdy_o), W'(0));
        exp_q.delete();
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_post_val", W'(rd_resp_val_o), W'(0));
        next_cycle();
        for (int j = 0; j < 3; j++) begin
            rd_req_val_i = 1'b1;
            rd_req_addr_i = AW'(6 + j);
            @(negedge clk);
            chk("t6_credit_rdy", W'(rd_req_rdy_o), W'(j < 2));
            if (rd_req_rdy_o) begin
                next_cycle();
            end else begin
                rd_req_val_i = 1'b0;
                next_cycle();
            end
        end
        rd_req_val_i = 1'b0;
        drain(10);

        repeat (3) next_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
